// File: rtl/ahb3lite_slave_arbiter.sv
// Per-slave-port master arbiter for an AHB3-Lite switch: priority plus round-robin
// address-phase grant, burst/lock hold, and data-phase owner tracking.
`timescale 1ns/1ps
module ahb3lite_slave_arbiter #(
  parameter  int MASTERS   = 3,
  parameter  int PRIO_BITS = 3,
  localparam int IDW       = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
  input  logic                           HCLK,
  input  logic                           HRESETn,
  input  logic [MASTERS-1:0]             mst_req,
  input  logic [MASTERS*PRIO_BITS-1:0]   mst_priority,
  input  logic [MASTERS*2-1:0]           mst_HTRANS,
  input  logic [MASTERS*3-1:0]           mst_HBURST,
  input  logic [MASTERS-1:0]             mst_HMASTLOCK,
  input  logic                           slv_HREADY,
  output logic [MASTERS-1:0]             gnt,
  output logic [IDW-1:0]                 gnt_id,
  output logic                           gnt_valid,
  output logic [IDW-1:0]                 dp_id,
  output logic                           dp_valid
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, NONSEQ = 2'd2, SEQ = 2'd3} htrans_e;
  typedef enum logic [2:0] {
    SINGLE = 3'd0, INCR = 3'd1, WRAP4 = 3'd2, INCR4 = 3'd3,
    WRAP8 = 3'd4, INCR8 = 3'd5, WRAP16 = 3'd6, INCR16 = 3'd7
  } hburst_e;

  logic [MASTERS-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]     gnt_id_q, gnt_id_d, dp_id_q, dp_id_d, rr_q, rr_d;
  logic               gnt_valid_q, gnt_valid_d, dp_valid_q, dp_valid_d;
  logic [3:0]         beats_q, beats_d;

  htrans_e  ownTrans;
  hburst_e  ownBurst;
  logic     ownReq, ownLock, ownFixed, hold;
  logic     found;
  logic [IDW-1:0]       win;
  logic [PRIO_BITS-1:0] bestPrio;

  assign ownTrans = htrans_e'(mst_HTRANS[2*gnt_id_q +: 2]);
  assign ownBurst = hburst_e'(mst_HBURST[3*gnt_id_q +: 3]);
  assign ownReq   = mst_req[gnt_id_q];
  assign ownLock  = mst_HMASTLOCK[gnt_id_q];
  assign ownFixed = (ownBurst != SINGLE) && (ownBurst != INCR);

  // Highest priority wins; ties resolved by scanning from the slot after the last winner.
  always_comb begin
    int idx;
    found    = 1'b0;
    win      = '0;
    bestPrio = '0;
    idx      = 0;
    for (int k = 1; k <= MASTERS; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= MASTERS) idx = idx - MASTERS;
      if (mst_req[idx] &&
          (!found || mst_priority[idx*PRIO_BITS +: PRIO_BITS] > bestPrio)) begin
        found    = 1'b1;
        win      = IDW'(idx);
        bestPrio = mst_priority[idx*PRIO_BITS +: PRIO_BITS];
      end
    end
  end

  always_comb begin
    beats_d = beats_q;
    if (slv_HREADY && ownReq) begin
      unique case (ownTrans)
        NONSEQ: begin
          unique case (ownBurst)
            WRAP4, INCR4:   beats_d = 4'd3;
            WRAP8, INCR8:   beats_d = 4'd7;
            WRAP16, INCR16: beats_d = 4'd15;
            default:        beats_d = 4'd0;
          endcase
        end
        SEQ:     beats_d = (beats_q != 4'd0) ? beats_q - 4'd1 : 4'd0;
        default: beats_d = beats_q;
      endcase
    end
  end

  // Bursts and locked sequences keep the current owner; beats_d is the post-edge count.
  always_comb begin
    hold = 1'b0;
    if (ownReq) begin
      if (ownLock)
        hold = 1'b1;
      else if (ownTrans == NONSEQ && ownBurst != SINGLE && !(ownFixed && beats_d == 4'd0))
        hold = 1'b1;
      else if (ownTrans == SEQ && ownFixed && beats_d != 4'd0)
        hold = 1'b1;
      else if ((ownTrans == SEQ || ownTrans == BUSY) && ownBurst == INCR)
        hold = 1'b1;
      else if (ownTrans == BUSY && ownFixed)
        hold = 1'b1;
    end
  end

  always_comb begin
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    rr_d        = rr_q;
    dp_id_d     = dp_id_q;
    dp_valid_d  = dp_valid_q;
    if (slv_HREADY) begin
      dp_id_d    = gnt_id_q;
      dp_valid_d = gnt_valid_q && (ownTrans == NONSEQ || ownTrans == SEQ);
      if (hold) begin
        gnt_valid_d = 1'b1;
      end else if (found) begin
        gnt_d       = '0;
        gnt_d[win]  = 1'b1;
        gnt_id_d    = win;
        gnt_valid_d = 1'b1;
        rr_d        = win;
      end else begin
        gnt_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      gnt_q       <= MASTERS'(1);
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      dp_id_q     <= '0;
      dp_valid_q  <= 1'b0;
      beats_q     <= 4'd0;
      rr_q        <= IDW'(MASTERS - 1);
    end else begin
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      dp_id_q     <= dp_id_d;
      dp_valid_q  <= dp_valid_d;
      beats_q     <= beats_d;
      rr_q        <= rr_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
  assign dp_id     = dp_id_q;
  assign dp_valid  = dp_valid_q;

endmodule

// File: doc/ahb3lite_slave_arbiter.md
# ahb3lite_slave_arbiter

Per-slave-port master arbiter for the AHB3-Lite interconnect switch. One instance sits in front of each slave port. It picks which requesting master owns that slave's address phase, and tracks the data-phase owner so read data and response route back correctly. Selection is priority first, with round-robin among equal priorities. Fixed-length bursts, undefined-length bursts and HMASTLOCK sequences are never split.

## Interface

Parameters:
- MASTERS, 3, number of master ports (2..16)
- PRIO_BITS, 3, width of each master priority field

Ports:
- HCLK  in  1  clock; all state changes on rising edge
- HRESETn  in  1  asynchronous active-low reset
- mst_req  in  MASTERS  bit m: master m has HSEL, address decoded to this slave, and HTRANS≠IDLE
- mst_priority  in  MASTERS*PRIO_BITS  field m: priority of master m; higher value wins
- mst_HTRANS  in  MASTERS*2  field m: HTRANS of master m (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
- mst_HBURST  in  MASTERS*3  field m: HBURST of master m (SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7)
- mst_HMASTLOCK  in  MASTERS  bit m: HMASTLOCK of master m
- slv_HREADY  in  1  HREADYOUT of the attached slave
- gnt  out  MASTERS  one-hot address-phase owner (always exactly one bit set; parks when idle)
- gnt_id  out  max(1,clog2(MASTERS))  binary index of gnt
- gnt_valid  out  1  owner is actively requesting this slave
- dp_id  out  max(1,clog2(MASTERS))  data-phase owner index, for HRDATA/HRESP/HREADY return muxing
- dp_valid  out  1  a data phase is in progress on this slave

## Operation

- Owner signals: HTRANS, HBURST, HMASTLOCK and req of master gnt_id.
- Commit point: gnt, gnt_id, gnt_valid, dp_id and dp_valid change only on an HCLK edge with slv_HREADY=1. With slv_HREADY=0, every register holds, including the beat counter and the RR pointer.
- Beat counter beats_left, 4 bits, belongs to the owner. It changes only when slv_HREADY=1 and the owner's req=1:
  - NONSEQ with WRAP4/INCR4: load 3.
  - NONSEQ with WRAP8/INCR8: load 7.
  - NONSEQ with WRAP16/INCR16: load 15.
  - NONSEQ with SINGLE or INCR: load 0.
  - SEQ: decrement, saturating at 0.
  - BUSY or IDLE: hold.
- Hold (no re-arbitration at this edge) when either condition is true:
  - (a) owner's HMASTLOCK=1 and owner's req=1.
  - (b) owner's req=1 and one of:
    - NONSEQ with HBURST∉{SINGLE} and not a fixed burst already at its last beat;
    - SEQ with post-edge beats_left≠0 for fixed bursts;
    - SEQ or BUSY with HBURST=INCR;
    - BUSY within a fixed burst.
  - Consequence: the edge that accepts the last fixed-burst beat re-arbitrates. An INCR burst releases only when the owner shows IDLE, drops req, or issues a NONSEQ SINGLE.
- Arbitrate (not holding, slv_HREADY=1):
  - Candidates are all m with mst_req[m]=1. The winner has the maximum mst_priority.
  - Ties go to the first candidate at or after index (rr_ptr+1) mod MASTERS, wrapping.
  - Winner loads gnt/gnt_id and gnt_valid=1. rr_ptr loads the winner's index.
  - No candidates: gnt/gnt_id keep their value (park), gnt_valid=0, rr_ptr unchanged.
- Data phase, on every edge with slv_HREADY=1:
  - dp_id ← gnt_id.
  - dp_valid ← gnt_valid AND owner HTRANS∈{NONSEQ, SEQ}.
- Priority changes take effect at the next arbitration edge only. They never preempt a hold.
- Reset values: gnt=1 (master 0), gnt_id=0, gnt_valid=0, dp_id=0, dp_valid=0, beats_left=0, rr_ptr=MASTERS-1 (master 0 first). Reset mid-burst or mid-lock abandons the transfer immediately.

## Timing

- Grant latency: with slv_HREADY=1 and the slave free, a master raising req in cycle N sees gnt in cycle N+1. The switch stalls non-owners via their HREADY (outside this block).
- Data-phase tracking: dp_id lags gnt by exactly one accepted transfer.
- The arbitration decision is combinational on inputs sampled at the commit edge. Outputs are registered with no combinational input→output path.
- Back-to-back handover: the last beat of owner A and the first NONSEQ of winner B fall in consecutive cycles, with no idle cycle inserted.

## Test plan

- Reset: hold HRESETn=0 → gnt=1, gnt_id=0, gnt_valid=0, dp_valid=0. Release, masters 1 and 2 request at equal priority 3 → master 1 granted first, then master 2 after master 1 goes IDLE.
- Priority: masters 0 and 2 request together, priorities 1 and 5 → gnt_id=2. Master 0 is granted only after master 2 drops req.
- INCR8 burst by master 0 with two BUSY cycles and slv_HREADY=0 for 3 cycles, while master 1 (higher priority 7) requests:
  - gnt stays on 0 through all 8 SEQ/NONSEQ beats;
  - gnt_id=1 on the edge after the 8th accepted beat;
  - dp_id=0 for exactly one further accepted transfer.
- Lock: master 1 asserts HMASTLOCK across two SINGLE NONSEQs with an IDLE-free gap, while master 0 has higher priority → master 1 holds. Release occurs on the first edge with HMASTLOCK=0.
- Round-robin fairness: all three masters request continuously, equal priority, SINGLE transfers → grant sequence 0,1,2,0,1,2.
- Reset mid-burst: assert HRESETn=0 during beat 3 of WRAP4 → outputs take reset values asynchronously. After release, the new burst from master 2 is granted with beats_left reloaded.
